uart_sim_transmitter: RTL and testbench
=======================================

UART_SIM_TRANSMITTER -- requirements
Module: uart_sim_transmitter

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 19200, serial bit rate in bit/s.
REQ-002 SHALL have parameter CLOCK_FREQ, default 100000000, clk_i frequency in Hz.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, transmit buffer entries; power of two, minimum 2.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rstn_i, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port data_i, input, 8 bits: byte to transmit.
REQ-007 SHALL have port valid_i, input, 1 bit: data_i is valid.
REQ-008 SHALL have port ready_o, output, 1 bit: buffer can accept a byte this cycle.
REQ-009 SHALL have port txd_o, output, 1 bit: serial line, idle high; connects to the DUT's uart0_rxd_i.
REQ-010 SHALL have port busy_o, output, 1 bit: a frame is in progress or the buffer is non-empty.

Function
REQ-011 SHALL define the bit period DIV = CLOCK_FREQ / BAUD_RATE, integer-truncated; e.g. 5208 cycles at the defaults.
REQ-012 SHALL accept a byte on every rising edge where valid_i and ready_o are both high; no other edge writes the buffer.
REQ-013 SHALL drive ready_o high exactly when the buffer holds fewer than FIFO_DEPTH entries, combinationally from the registered count.
REQ-014 SHALL transmit 8N1 frames: start bit 0, data bits LSB first, stop bit 1; each bit lasts exactly DIV cycles; one frame is 10*DIV cycles.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 In IDLE with a non-empty buffer, SHALL pop one byte and enter START on the same edge; txd_o is registered and reads 0 from that edge.
REQ-017 Latency: a byte written at edge N into an empty buffer while in IDLE SHALL make txd_o fall at edge N+1.
REQ-018 SHALL move START->DATA after DIV cycles, DATA->STOP after 8 bit periods (3-bit index wraps 7->0), and leave STOP after DIV cycles.
REQ-019 At the end of STOP with a non-empty buffer, SHALL pop and enter START directly with no idle gap; with an empty buffer, SHALL enter IDLE.
REQ-020 A simultaneous push and pop SHALL leave the count unchanged and preserve FIFO order.
REQ-021 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 A push while full is impossible by REQ-012; data_i SHALL then be ignored with no overwrite.
REQ-023 busy_o SHALL be high when the state is not IDLE or the count is non-zero.

Reset
REQ-024 On rstn_i low, SHALL immediately and asynchronously force: state IDLE, txd_o 1, count 0, both pointers 0, baud counter 0, bit index 0.
REQ-025 Reset SHALL therefore give ready_o 1 and busy_o 0.
REQ-026 Reset mid-frame SHALL abort the frame, drive txd_o high at once, and discard all buffered bytes; buffer storage contents need not be reset.
REQ-027 After rstn_i rises, the first accepted byte SHALL follow REQ-017 exactly.

Structure
REQ-028 SHALL keep the state encoding, the frame length constant (10), and the DIV computation in a shared package/include used by this block and the UART simulation receiver.
REQ-029 SHALL place the buffer in one sub-module, uart_sim_tx_fifo, parameterised by FIFO_DEPTH and width 8, providing push/pop/full/empty/count.
REQ-030 SHALL be synthesizable and contain no delays or simulation-only constructs.

Verification
REQ-031 Defaults; push 0x4E at edge N -> txd_o 0 from N+1, then bits 0,1,1,1,0,0,1,0 at 5208 cycles each, stop 1; busy_o low 52080 cycles after N+1.
REQ-032 Loopback to the UART simulation receiver (19200 baud, 100 MHz); push "NEORV32" back-to-back -> receiver outputs the 7 chars in order; no idle gap between frames.
REQ-033 Hold valid_i high from idle with 6 distinct bytes -> 5 accepted (ready_o low after the 5th edge), the 6th held until the first frame ends; all 6 later transmitted in order.
REQ-034 Assert rstn_i low mid-DATA of 0xA5 with 2 bytes buffered -> txd_o 1 immediately, ready_o 1, busy_o 0; after release, push 0x55 -> only 0x55 frame appears.
REQ-035 BAUD_RATE 1000000 with CLOCK_FREQ 100000000 -> DIV 100; frame for 0xFF is exactly 100 cycles low, then 900 cycles high.

Source files
------------

// File: rtl/uart_sim_transmitter_pkg.sv
// Shared definitions for the UART simulation transmitter and receiver:
// FSM state encoding, frame geometry and the bit-period computation.
package uart_sim_transmitter_pkg;

    // Serial line FSM states shared by the transmitter and the receiver
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // 8N1 frame: one start bit, eight data bits, one stop bit
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

    // Clock cycles per serial bit, truncated toward zero
    function automatic int calc_div(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sim_tx_fifo.sv
// Small transmit buffer: DEPTH entries of WIDTH bits, first-in first-out.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// The read port is combinational so a byte can be popped and used on the
// same edge; storage itself is never reset, only the pointers and count.
module uart_sim_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    // A push while full or a pop while empty is dropped so the pointers
    // and the stored data can never be corrupted.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rd_data = mem[rd_ptr_reg];

    // Per-entry storage write, selected by the write pointer
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg == AW'(gi))) begin
                mem[gi] <= wr_data;
            end
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_sim_transmitter.sv
// Buffered 8N1 UART transmitter used to feed serial stimulus into a DUT.
// Bytes are queued in a small FIFO and shifted out LSB first, one bit per
// DIV clock cycles. Consecutive buffered bytes go out with no idle gap.
module uart_sim_transmitter
    import uart_sim_transmitter_pkg::*;
#(
    parameter int BAUD_RATE  = 19200,
    parameter int CLOCK_FREQ = 100000000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       txd_o,
    output logic       busy_o
);

    localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE);
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] DIV_LAST = BW'(DIV - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    uart_state_t   state_reg;
    uart_state_t   state_next;
    logic [BW-1:0] baud_reg;
    logic [BW-1:0] baud_next;
    logic [2:0]    bit_reg;
    logic [2:0]    bit_next;
    logic [2:0]    bit_inc;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_next;
    logic          txd_reg;
    logic          txd_next;
    logic          tick;

    logic          push;
    logic          pop;
    logic [7:0]    fifo_rd_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // Full is derived from the registered count, so ready is glitch-free
    assign ready_o = ~fifo_full;
    assign push    = valid_i && ready_o;
    assign busy_o  = (state_reg != ST_IDLE) || (fifo_count != '0);
    assign txd_o   = txd_reg;

    // Last cycle of the current bit period
    assign tick    = (baud_reg == DIV_LAST);
    assign bit_inc = bit_reg + 3'd1;

    uart_sim_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk_i),
        .rstn    (rstn_i),
        .push    (push),
        .pop     (pop),
        .wr_data (data_i),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // State register plus the registered datapath and serial output
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= ST_IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            txd_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            txd_reg   <= txd_next;
        end
    end

    // Next-state logic: frame sequencing, chaining straight from STOP to
    // START when another byte is already waiting
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick && (bit_reg == BIT_LAST)) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_next = fifo_empty ? ST_IDLE : ST_START;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic: FIFO pop, baud/bit counters, shifter load and the next
    // serial level, so txd changes on the same edge as the state
    always_comb begin
        pop        = 1'b0;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        txd_next   = txd_reg;
        case (state_reg)
            ST_IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_rd_data;
                    txd_next   = 1'b0;
                end else begin
                    txd_next   = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    baud_next = '0;
                    bit_next  = '0;
                    txd_next  = shift_reg[0];
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            ST_DATA: begin
                if (tick) begin
                    baud_next = '0;
                    // 3-bit index wraps 7 -> 0 as the last data bit ends
                    bit_next  = bit_inc;
                    if (bit_reg == BIT_LAST) begin
                        txd_next = 1'b1;
                    end else begin
                        txd_next = shift_reg[bit_inc];
                    end
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            ST_STOP: begin
                if (tick) begin
                    baud_next = '0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_rd_data;
                        txd_next   = 1'b0;
                    end else begin
                        txd_next   = 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            default: begin
                baud_next = '0;
                txd_next  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_sim_transmitter.sv
// Directed bench for uart_sim_transmitter: a fast instance (DIV = 100) for
// most scenarios and a default-parameter instance (DIV = 5208) for the
// nominal 19200 baud frame.
module tb_uart_sim_transmitter;

    localparam int FAST_DIV = 100;
    localparam int DEF_DIV  = 5208;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] data_f = 8'h00;
    logic       valid_f = 1'b0;
    logic [7:0] data_d = 8'h00;
    logic       valid_d = 1'b0;
    logic       ready_f, txd_f, busy_f;
    logic       ready_d, txd_d, busy_d;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    uart_sim_transmitter #(
        .BAUD_RATE  (1000000),
        .CLOCK_FREQ (100000000),
        .FIFO_DEPTH (4)
    ) dut_fast (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .data_i  (data_f),
        .valid_i (valid_f),
        .ready_o (ready_f),
        .txd_o   (txd_f),
        .busy_o  (busy_f)
    );

    uart_sim_transmitter dut_def (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .data_i  (data_d),
        .valid_i (valid_d),
        .ready_o (ready_d),
        .txd_o   (txd_d),
        .busy_o  (busy_d)
    );

    function automatic logic get_txd(input int w);
        return (w != 0) ? txd_d : txd_f;
    endfunction

    function automatic logic get_busy(input int w);
        return (w != 0) ? busy_d : busy_f;
    endfunction

    function automatic logic get_ready(input int w);
        return (w != 0) ? ready_d : ready_f;
    endfunction

    task automatic drive(input int w, input logic v, input logic [7:0] d);
        if (w != 0) begin
            valid_d = v;
            data_d  = d;
        end else begin
            valid_f = v;
            data_f  = d;
        end
    endtask

    // Present one byte for exactly one edge; returns at that edge + 1
    task automatic push_one(input int w, input logic [7:0] d);
        @(negedge clk);
        drive(w, 1'b1, d);
        @(posedge clk);
        #1;
        drive(w, 1'b0, d);
    endtask

    // Called at start edge S + 1; samples each bit mid-period, returns at
    // S + 10*div + 1 with busy sampled one cycle before the frame end
    task automatic capture_frame(input int w, input int div,
                                 output logic [9:0] bits, output logic busy_late);
        repeat (div / 2) @(posedge clk);
        #1;
        bits[0] = get_txd(w);
        for (int k = 1; k < 10; k++) begin
            repeat (div) @(posedge clk);
            #1;
            bits[k] = get_txd(w);
        end
        repeat (div - div / 2 - 1) @(posedge clk);
        #1;
        busy_late = get_busy(w);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fall(input int w, input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (get_txd(w) == 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // One byte into an idle transmitter: latency, frame content, busy timing
    task automatic run_single(input int w, input int div, input logic [7:0] d,
                              input string name);
        logic [9:0] bits;
        logic       busy_late;
        push_one(w, d);
        total_cnt++;
        if (get_txd(w) !== 1'b1)
            $display("FAIL %s_pre_edge txd=%b expected 1", name, get_txd(w));
        else pass_cnt++;
        total_cnt++;
        if (get_busy(w) !== 1'b1)
            $display("FAIL %s_busy_queued busy=%b expected 1", name, get_busy(w));
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (get_txd(w) !== 1'b0)
            $display("FAIL %s_latency txd=%b expected 0", name, get_txd(w));
        else pass_cnt++;
        capture_frame(w, div, bits, busy_late);
        $display("dut%0d %s frame bits=%b byte=0x%02h", w, name, bits, bits[8:1]);
        total_cnt++;
        if (bits !== {1'b1, d, 1'b0})
            $display("FAIL %s_frame bits=%b expected %b", name, bits, {1'b1, d, 1'b0});
        else pass_cnt++;
        total_cnt++;
        if (busy_late !== 1'b1)
            $display("FAIL %s_busy_last_cycle busy=%b expected 1", name, busy_late);
        else pass_cnt++;
        total_cnt++;
        if (get_busy(w) !== 1'b0 || get_txd(w) !== 1'b1)
            $display("FAIL %s_frame_end busy=%b txd=%b expected busy 0 txd 1",
                     name, get_busy(w), get_txd(w));
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({txd_f, ready_f, busy_f} !== 3'b110)
            $display("FAIL reset_fast txd/ready/busy=%b expected 110", {txd_f, ready_f, busy_f});
        else pass_cnt++;
        total_cnt++;
        if ({txd_d, ready_d, busy_d} !== 3'b110)
            $display("FAIL reset_def txd/ready/busy=%b expected 110", {txd_d, ready_d, busy_d});
        else pass_cnt++;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({txd_f, ready_f, busy_f} !== 3'b110)
            $display("FAIL post_reset_idle txd/ready/busy=%b expected 110", {txd_f, ready_f, busy_f});
        else pass_cnt++;
    endtask

    task automatic test_latency();
        run_single(0, FAST_DIV, 8'h4E, "fast_4e");
    endtask

    // 0xFF at DIV 100: exactly 100 low cycles, then 900 high cycles
    task automatic test_exact_ff();
        int low_cnt = 0;
        int first_high = -1;
        push_one(0, 8'hFF);
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            if (txd_f == 1'b0) low_cnt++;
            else if (first_high < 0) first_high = c;
        end
        $display("dut0 ff frame low_cycles=%0d first_high=%0d", low_cnt, first_high);
        total_cnt++;
        if (low_cnt != 100)
            $display("FAIL ff_low_cycles got=%0d expected 100", low_cnt);
        else pass_cnt++;
        total_cnt++;
        if (first_high != 100)
            $display("FAIL ff_first_high got=%0d expected 100", first_high);
        else pass_cnt++;
        total_cnt++;
        if (busy_f !== 1'b1)
            $display("FAIL ff_busy_last busy=%b expected 1", busy_f);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (busy_f !== 1'b0)
            $display("FAIL ff_busy_end busy=%b expected 0", busy_f);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [7] = '{8'h4E, 8'h45, 8'h4F, 8'h52, 8'h56, 8'h33, 8'h32};
        logic       push_timeout = 1'b0;
        logic       ok;
        logic [9:0] bits;
        logic       busy_late;
        fork
            begin
                for (int i = 0; i < 7; i++) begin
                    int guard = 0;
                    @(negedge clk);
                    while (!ready_f && guard < 5000) begin
                        @(negedge clk);
                        guard++;
                    end
                    if (guard >= 5000) push_timeout = 1'b1;
                    data_f  = msg[i];
                    valid_f = 1'b1;
                    @(posedge clk);
                    #1;
                    valid_f = 1'b0;
                end
            end
            begin
                wait_fall(0, 2000, ok);
                total_cnt++;
                if (ok !== 1'b1)
                    $display("FAIL b2b_first_start txd=%b expected 0 within 2000 cycles", txd_f);
                else pass_cnt++;
                for (int k = 0; k < 7; k++) begin
                    if (k > 0) begin
                        total_cnt++;
                        if (txd_f !== 1'b0)
                            $display("FAIL b2b_gap_%0d txd=%b expected 0", k, txd_f);
                        else pass_cnt++;
                    end
                    capture_frame(0, FAST_DIV, bits, busy_late);
                    $display("dut0 b2b frame %0d byte=0x%02h", k, bits[8:1]);
                    total_cnt++;
                    if (bits !== {1'b1, msg[k], 1'b0})
                        $display("FAIL b2b_frame_%0d bits=%b expected %b", k, bits, {1'b1, msg[k], 1'b0});
                    else pass_cnt++;
                end
            end
        join
        total_cnt++;
        if (push_timeout !== 1'b0 || busy_f !== 1'b0)
            $display("FAIL b2b_end timeout=%b busy=%b expected 0 0", push_timeout, busy_f);
        else pass_cnt++;
    endtask

    // Hold valid from idle with 6 bytes into a 4-deep buffer
    task automatic test_full();
        logic [7:0] b [6] = '{8'h13, 8'h57, 8'h9B, 8'hDF, 8'h24, 8'h68};
        logic       ok;
        logic [9:0] bits;
        logic       busy_late;
        int         wait_cycles = 0;
        fork
            begin
                @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    data_f  = b[i];
                    valid_f = 1'b1;
                    @(posedge clk);
                    #1;
                    if (i == 3) begin
                        total_cnt++;
                        if (ready_f !== 1'b1)
                            $display("FAIL full_ready_edge4 ready=%b expected 1", ready_f);
                        else pass_cnt++;
                    end
                end
                total_cnt++;
                if (ready_f !== 1'b0)
                    $display("FAIL full_ready_edge5 ready=%b expected 0", ready_f);
                else pass_cnt++;
                data_f = b[5];
                while (!ready_f && wait_cycles < 20 * FAST_DIV) begin
                    @(posedge clk);
                    #1;
                    wait_cycles++;
                end
                total_cnt++;
                if (wait_cycles != 10 * FAST_DIV - 3)
                    $display("FAIL full_ready_return cycles=%0d expected %0d", wait_cycles, 10 * FAST_DIV - 3);
                else pass_cnt++;
                @(posedge clk);
                #1;
                valid_f = 1'b0;
            end
            begin
                wait_fall(0, 100, ok);
                total_cnt++;
                if (ok !== 1'b1)
                    $display("FAIL full_first_start txd=%b expected 0 within 100 cycles", txd_f);
                else pass_cnt++;
                for (int k = 0; k < 6; k++) begin
                    capture_frame(0, FAST_DIV, bits, busy_late);
                    $display("dut0 full frame %0d byte=0x%02h", k, bits[8:1]);
                    total_cnt++;
                    if (bits !== {1'b1, b[k], 1'b0})
                        $display("FAIL full_frame_%0d bits=%b expected %b", k, bits, {1'b1, b[k], 1'b0});
                    else pass_cnt++;
                end
            end
        join
        total_cnt++;
        if (busy_f !== 1'b0)
            $display("FAIL full_end busy=%b expected 0", busy_f);
        else pass_cnt++;
    endtask

    // Asynchronous reset in the middle of a data bit with bytes queued
    task automatic test_reset_mid();
        int low_seen = 0;
        push_one(0, 8'hA5);
        push_one(0, 8'h11);
        push_one(0, 8'h22);
        repeat (3 * FAST_DIV + 50) @(posedge clk);
        #1;
        total_cnt++;
        if (busy_f !== 1'b1 || ready_f !== 1'b1)
            $display("FAIL rst_mid_before busy=%b ready=%b expected 1 1", busy_f, ready_f);
        else pass_cnt++;
        #1;
        rstn = 1'b0;
        #1;
        total_cnt++;
        if ({txd_f, ready_f, busy_f} !== 3'b110)
            $display("FAIL rst_mid_async txd/ready/busy=%b expected 110", {txd_f, ready_f, busy_f});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        run_single(0, FAST_DIV, 8'h55, "after_reset_55");
        for (int c = 0; c < 3 * FAST_DIV; c++) begin
            @(posedge clk);
            #1;
            if (txd_f == 1'b0 || busy_f == 1'b1) low_seen++;
        end
        total_cnt++;
        if (low_seen != 0)
            $display("FAIL rst_mid_stale_frames activity_cycles=%0d expected 0", low_seen);
        else pass_cnt++;
    endtask

    task automatic test_default_frame();
        run_single(1, DEF_DIV, 8'h4E, "default_4e");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_exact_ff();
        test_back_to_back();
        test_full();
        test_reset_mid();
        test_default_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog simulation time limit reached passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
